// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the core's data-store bus.
// Contents:
//   UART_TXDATA_OFS / UART_STATUS_OFS : register offsets from the UART base address
//   STATUS_*_BIT                      : bit positions inside the UART STATUS word
//   uart_tx_state_t                   : serializer state encoding
//   pack_uart_status()                : assembles the STATUS readback word
package riscv_mmio_pkg;

    localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_BUSY_BIT  = 2;
    localparam int STATUS_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    function automatic logic [31:0] pack_uart_status(
        input logic ovf,
        input logic busy,
        input logic full,
        input logic empty
    );
        logic [31:0] word;
        word                   = '0;
        word[STATUS_OVF_BIT]   = ovf;
        word[STATUS_BUSY_BIT]  = busy;
        word[STATUS_FULL_BIT]  = full;
        word[STATUS_EMPTY_BIT] = empty;
        return word;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-store bus as seen by a memory-mapped peripheral.
//   we    : store strobe from the core
//   addr  : byte address
//   wdata : store data
//   rdata : peripheral readback (0 when the address is not decoded)
//   hit   : peripheral decodes the current address
// master = core side, slave = peripheral side.
interface mmio_uart_tx_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output we, output addr, output wdata, input rdata, input hit);
    modport slave  (input we, input addr, input wdata, output rdata, output hit);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
//   clk, rst : clock, asynchronous active-high reset (pointers and count only)
//   push     : write din; accepted when not full, or when full and popping the same edge
//   pop      : advance the head; ignored when empty
//   din      : write data
//   dout     : current head entry (valid while !empty)
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_CNT);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally so the consumer can pop and capture in one edge.
    assign dout = mem[rd_ptr_reg];

    // Storage carries no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory on the store bus.
//   clk  : system clock
//   rst  : asynchronous active-high reset; aborts any frame, tx returns high at once
//   bus  : store bus (slave side) - we/addr/wdata in, rdata/hit out
//          BASE+0 TXDATA : store pushes wdata[7:0]; reads return 0
//          BASE+4 STATUS : {28'b0, overflow, busy, full, empty}; any store clears overflow
//   tx   : serial line, idle high, driven from a register
module mmio_uart_tx
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic txdata_sel;
    logic status_sel;
    logic push_req;
    logic status_wr;
    logic unused_wdata_hi;

    assign txdata_sel      = (bus.addr == BASE_ADDR + UART_TXDATA_OFS);
    assign status_sel      = (bus.addr == BASE_ADDR + UART_STATUS_OFS);
    assign push_req        = bus.we && txdata_sel;
    assign status_wr       = bus.we && status_sel;
    assign unused_wdata_hi = ^bus.wdata[31:8];

    // ---------------- TX FIFO ----------------
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- overflow flag ----------------
    logic ovf_reg;
    logic ovf_set;

    // A push is lost only when the FIFO is full and nothing leaves that edge.
    assign ovf_set = push_req && fifo_full && !fifo_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (ovf_set) begin
            ovf_reg <= 1'b1;            // set beats a simultaneous clear
        end else if (status_wr) begin
            ovf_reg <= 1'b0;
        end
    end

    // ---------------- serializer FSM ----------------
    uart_tx_state_t    state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic              baud_done;

    assign baud_done = (baud_reg == BAUD_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    // Next-state logic; the head byte is popped on the same edge that enters START,
    // which is what leaves exactly one idle cycle between back-to-back frames.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        fifo_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_dout;
                    state_next   = START;
                    baud_next    = '0;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_next = IDLE;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: the line level is computed from the upcoming state so the
    // registered tx lines up with state_reg without a cycle of lag.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // ---------------- outputs ----------------
    logic busy;

    assign busy      = (state_reg != IDLE) || (fifo_count != '0);
    assign tx        = tx_reg;
    assign bus.hit   = txdata_sel || status_sel;
    assign bus.rdata = status_sel ? pack_uart_status(ovf_reg, busy, fifo_full, fifo_empty) : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;
    localparam int          CPB  = 4;

    logic clk = 1'b0;
    logic rst;
    logic tx;

    mmio_uart_tx_if bus_if();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    byte unsigned rx_q[$];
    int           rx_start_q[$];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        ticks(1);
        $display("store addr=0x%08h data=0x%08h t=%0d", a, d, cyc);
        bus_if.we   = 1'b0;
        bus_if.addr = STAT;
        #1;
    endtask

    task automatic wait_status(input logic [31:0] want, input int limit, input string name);
        int n;
        n = 0;
        while (bus_if.rdata !== want && n < limit) begin
            ticks(1);
            n++;
        end
        check(name, bus_if.rdata, want);
    endtask

    // Reference receiver: a plain UART decoder sampling in the middle of each bit.
    initial begin : monitor
        int         s0;
        logic [7:0] b;
        bit         ok;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst === 1'b0 && tx === 1'b0) begin
                s0 = cyc;
                ok = 1'b1;
                b  = '0;
                ticks(2);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    ticks(CPB);
                    b[i] = tx;
                end
                ticks(CPB);
                if (tx !== 1'b1) ok = 1'b0;
                if (mon_en) begin
                    check("uart_frame", 32'(ok), 32'd1);
                    rx_q.push_back(b);
                    rx_start_q.push_back(s0);
                    $display("rx byte=0x%02h start=%0d", b, s0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          lat;
        int          drop_cyc;
        int          n_burst;
        logic [7:0]  b;
        logic [7:0]  data55;
        logic [7:0]  exp_bytes[5];
        logic        exp_tx;
        byte unsigned exp_q[$];

        bus_if.we    = 1'b0;
        bus_if.addr  = STAT;
        bus_if.wdata = '0;
        rst          = 1'b1;
        ticks(3);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_status", bus_if.rdata, 32'h1);
        check("reset_hit", 32'(bus_if.hit), 32'd1);
        rst = 1'b0;
        ticks(2);

        // ---- address decode table (idle, FIFO empty) ----
        vecs[0] = '{STAT,          1'b0, 1'b1, 32'h1};
        vecs[1] = '{BASE,          1'b0, 1'b1, 32'h0};
        vecs[2] = '{32'h1000_0008, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{32'h1000_0001, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{32'h1000_0005, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{32'h0000_0000, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{STAT,          1'b1, 1'b1, 32'h1};
        vecs[7] = '{32'h1000_0003, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{32'h2000_0004, 1'b1, 1'b0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            bus_if.we    = vecs[i].we;
            bus_if.addr  = vecs[i].addr;
            bus_if.wdata = 32'hFFFF_FF00 | 32'(i);
            #1;
            check($sformatf("vec%0d_hit", i), 32'(bus_if.hit), 32'(vecs[i].exp_hit));
            check($sformatf("vec%0d_rdata", i), bus_if.rdata, vecs[i].exp_rdata);
            ticks(1);
            $display("vec %0d addr=0x%08h we=%0b hit=%0b", i, vecs[i].addr, vecs[i].we, bus_if.hit);
            bus_if.we   = 1'b0;
            bus_if.addr = STAT;
            #1;
            check($sformatf("vec%0d_status_after", i), bus_if.rdata, 32'h1);
        end
        ticks(3);
        check("decode_no_tx", 32'(tx), 32'd1);

        // ---- single frame 0x55 ----
        rx_q.delete();
        rx_start_q.delete();
        mon_en = 1'b1;
        data55 = 8'h55;
        store(BASE, 32'hFFFF_FF55);
        lat = 0;
        while (tx !== 1'b0 && lat < 10) begin
            ticks(1);
            lat++;
        end
        check("start_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (k / CPB == 0)      exp_tx = 1'b0;
            else if (k / CPB == 9) exp_tx = 1'b1;
            else                   exp_tx = data55[k / CPB - 1];
            check($sformatf("frame55_k%0d", k), 32'(tx), 32'(exp_tx));
            ticks(1);
        end
        check("frame55_end_tx", 32'(tx), 32'd1);
        check("frame55_end_status", bus_if.rdata, 32'h1);
        check("frame55_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("frame55_rx_byte", 32'(rx_q[0]), 32'h55);

        // ---- five back-to-back stores, then overflow during STOP ----
        rx_q.delete();
        rx_start_q.delete();
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
        for (int i = 0; i < 5; i++) store(BASE, {24'hABCDEF, exp_bytes[i]});
        check("after5_status", bus_if.rdata, 32'h6);
        ticks(33);
        check("in_stop_before_6th", 32'(tx), 32'd1);
        store(BASE, 32'h0000_0077);
        check("overflow_status", bus_if.rdata, 32'hE);
        store(STAT, 32'h0);
        check("ovf_cleared_status", bus_if.rdata, 32'h6);
        wait_status(32'h1, 600, "drain_after_ovf");
        check("ovf_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check($sformatf("ovf_rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_bytes[i]));

        // ---- two frames back-to-back ----
        rx_q.delete();
        rx_start_q.delete();
        store(BASE, 32'h0000_00A5);
        store(BASE, 32'h0000_000F);
        lat = 0;
        while (bus_if.rdata[2] !== 1'b0 && lat < 200) begin
            ticks(1);
            lat++;
        end
        drop_cyc = cyc;
        check("b2b_busy_dropped", 32'(bus_if.rdata[2]), 32'd0);
        check("b2b_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("b2b_byte0", 32'(rx_q[0]), 32'hA5);
            check("b2b_byte1", 32'(rx_q[1]), 32'h0F);
            check("b2b_start_gap", 32'(rx_start_q[1] - rx_start_q[0]), 32'(10 * CPB + 1));
            check("b2b_busy_drop_time", 32'(drop_cyc - rx_start_q[1]), 32'(10 * CPB));
        end

        // ---- reset during DATA bit 3 ----
        mon_en = 1'b0;
        store(BASE, 32'h0);
        store(BASE, 32'h0);
        store(BASE, 32'h0);
        lat = 0;
        while (tx !== 1'b0 && lat < 10) begin
            ticks(1);
            lat++;
        end
        ticks(CPB + 3 * CPB + 1);
        check("data_bit3_low", 32'(tx), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("reset_tx_immediate", 32'(tx), 32'd1);
        check("reset_mid_status", bus_if.rdata, 32'h1);
        check("reset_mid_hit", 32'(bus_if.hit), 32'd1);
        ticks(2);
        rst = 1'b0;
        ticks(1);
        check("post_reset_status", bus_if.rdata, 32'h1);
        ticks(50);
        check("post_reset_idle_tx", 32'(tx), 32'd1);
        check("post_reset_idle_status", bus_if.rdata, 32'h1);

        // ---- randomized bursts against the receiver model ----
        rx_q.delete();
        rx_start_q.delete();
        mon_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n_burst = $urandom_range(1, 4);
            for (int j = 0; j < n_burst; j++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                store(BASE, {$urandom} & 32'hFFFF_FF00 | 32'(b));
                ticks($urandom_range(0, 3));
            end
            wait_status(32'h1, 800, $sformatf("rand_drain%0d", r));
        end
        check("rand_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("rand_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
